pif_slave_memory_responder: RTL and testbench
=============================================

// Module: pif_slave_memory_responder
// PURPOSE
//  PIF responder (slave) that answers a core's outbound PIF requests from a local word memory.
//  Sits opposite an Xtensa core's outbound PIF in cosim testbenches.
//  Accepts single/block read and write requests; returns read data and write acks on the response channel.
//  Supports response back-pressure.
// PARAMETERS
//  DEPTH_LOG2    10  memory depth = 2**DEPTH_LOG2 32-bit words
//  READ_LATENCY  1   cycles from request accept to first read beat valid; 1..15
//  WRITE_LATENCY 1   cycles from last write beat accepted to ack valid; 1..15
// PORTS
//  CLK            in   1   clock; all state changes on rising edge
//  BReset         in   1   synchronous active-high reset
//  POReqValid     in   1   request beat valid
//  PIReqRdy       out  1   responder can accept a request beat
//  POReqCntl      in   8   [7:4] type, [2:1] block size, [0] last beat
//  POReqAdrs      in   32  byte address
//  POReqData      in   32  write data
//  POReqDataBE    in   4   write byte enables
//  POReqId        in   6   transaction id
//  POReqPriority  in   2   priority
//  PIRespValid    out  1   response beat valid
//  PORespRdy      in   1   core accepts response beat
//  PIRespCntl     out  8   [7:4] type, [3:1] error code, [0] last beat
//  PIRespData     out  32  read data
//  PIRespId       out  6   echoed ReqId
//  PIRespPriority out  2   echoed ReqPriority
// BEHAVIOUR
//  - Beat transfers when Valid&Rdy are high at a rising CLK.
//  - Request types: 0x0 single read; 0x8 single write; 0x1 block read; 0x9 block write.
//    Unknown types are answered with error code 3'b010.
//  - Block size [2:1]: 00=2, 01=4, 10=8, 11=16 beats. Ignored for single requests.
//  - Word index = POReqAdrs[DEPTH_LOG2+1:2]. Block start has low log2(beats) index bits cleared.
//    Beats increment the index.
//  - Response type: 0x0 read data, 0x1 write ack. Error code 000 = OK.
//  - Write merges bytes per DataBE; BE=0 writes nothing but is still acked.
//  - FSM states:
//    - IDLE: PIReqRdy=1. On accept:
//      - read -> RD_WAIT
//      - single write -> mem write, then WR_WAIT
//      - block write -> write beat 0, then WR_COLLECT
//    - WR_COLLECT: PIReqRdy=1.
//      - Each accepted beat writes the next word.
//      - A beat with Cntl[0]=1, or the final beat by count, -> WR_WAIT.
//      - A beat whose id differs from the captured id is written anyway, and error 3'b100 is flagged in the ack.
//    - RD_WAIT: count READ_LATENCY-1 cycles, then RD_RESP.
//    - RD_RESP: PIRespValid=1.
//      - Data read at beat issue and held stable while PORespRdy=0.
//      - Cntl[0]=1 on the last beat.
//      - After the last beat is accepted -> IDLE, with PIReqRdy=1 in the same cycle the FSM is back in IDLE.
//    - WR_WAIT: count WRITE_LATENCY-1 cycles, then WR_RESP.
//    - WR_RESP: one ack beat, Cntl[0]=1, held until PORespRdy -> IDLE.
//  - PIReqRdy=0 in RD_WAIT, RD_RESP, WR_WAIT and WR_RESP: one outstanding transaction.
//  - With READ_LATENCY=1, PIRespValid rises the cycle after accept.
//    Back-to-back block read beats issue every cycle while PORespRdy=1.
//  - Id and priority are captured at the first beat and echoed on every response beat.
//  - Reset values: PIReqRdy=0 in the reset cycle, 1 from the first cycle after reset.
//    PIRespValid=0, PIRespCntl=0, PIRespData=0, PIRespId=0, PIRespPriority=0, FSM=IDLE.
//  - Reset mid-transaction aborts it: no response is issued, and words already written stay written.
//  - Memory contents are not reset.
// CONFIGURATION
//  PIF_SLAVE_ADDR_ERR_EN
//   - Defined: address bits [31:DEPTH_LOG2+2] nonzero -> no memory access.
//     - Reads return data 0 with error 3'b001 on every beat.
//     - Write acks carry 3'b001.
//     - Handshake and beat count are unchanged.
//   - Undefined: upper address bits are ignored; the address aliases modulo the depth.
// TESTING
//  1. Single write adrs 0x10 data 0xDEADBEEF BE 4'hF id 5, then single read 0x10.
//     -> ack type 0x1 id 5 last=1; read data 0xDEADBEEF.
//  2. Write 0x11223344, then write 0xAABBCCDD with BE 4'b0101 at 0x20; read 0x20.
//     -> 0x11BB33DD.
//  3. Block write 4 beats at 0x40 (data 1..4), then block read 4 beats at 0x48.
//     -> beats 1,2,3,4 (aligned to 0x40); Cntl[0]=1 only on beat 4.
//  4. Block read 8 beats with PORespRdy low 3 cycles at beat 2.
//     -> beat 2 data held stable; PIReqRdy=0 until last beat accepted.
//  5. Read 0x0001_0000 with DEPTH_LOG2=10.
//     -> ERR_EN: data 0, error 3'b001; else aliases to word 0.
//  6. Assert BReset during RD_RESP beat 1 of 4.
//     -> next cycle PIRespValid=0, then PIReqRdy=1; new request served normally.

Source files
------------

// File: rtl/pif_slave_memory_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pif_slave_memory_responder                                               |
// | PIF slave that serves single/block reads and writes from a word memory.  |
// | Optional: PIF_SLAVE_ADDR_ERR_EN flags out-of-range addresses.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pif_slave_memory_responder #(
    parameter int DEPTH_LOG2    = 10,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        BReset,
    input  logic        POReqValid,
    output logic        PIReqRdy,
    input  logic [7:0]  POReqCntl,
    input  logic [31:0] POReqAdrs,
    input  logic [31:0] POReqData,
    input  logic [3:0]  POReqDataBE,
    input  logic [5:0]  POReqId,
    input  logic [1:0]  POReqPriority,
    output logic        PIRespValid,
    input  logic        PORespRdy,
    output logic [7:0]  PIRespCntl,
    output logic [31:0] PIRespData,
    output logic [5:0]  PIRespId,
    output logic [1:0]  PIRespPriority
);

    localparam int         DEPTH        = 1 << DEPTH_LOG2;
    localparam logic [3:0] RD_WAIT_INIT = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_WAIT_INIT = 4'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR_COLLECT = 3'd1,
        S_RD_WAIT    = 3'd2,
        S_RD_RESP    = 3'd3,
        S_WR_WAIT    = 3'd4,
        S_WR_RESP    = 3'd5
    } state_t;

    logic [31:0]           mem [DEPTH];
    state_t                state;
    logic [DEPTH_LOG2-1:0] base_idx;
    logic [3:0]            beat;
    logic [3:0]            last_beat;
    logic [3:0]            wait_cnt;
    logic [2:0]            err;
    logic [3:0]            resp_type;

    logic                  accept;
    logic [3:0]            req_type;
    logic                  is_rd_single, is_rd_block, is_wr_single, is_wr_block;
    logic                  is_read, is_block, is_unknown;
    logic [DEPTH_LOG2-1:0] req_idx, start_idx;
    logic [3:0]            blk_last;
    logic                  addr_err;
    logic                  id_err, wr_done;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_widx;
    logic                  rd_issue, rd_last, rd_err;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [31:0]           rd_data;
    logic                  ack_issue;
    logic [3:0]            ack_type;
    logic [2:0]            ack_err;
    logic [3:0]            beat_nxt;
    logic                  unused_bits;

    assign accept       = POReqValid && PIReqRdy;
    assign req_type     = POReqCntl[7:4];
    assign is_rd_single = (req_type == 4'h0);
    assign is_rd_block  = (req_type == 4'h1);
    assign is_wr_single = (req_type == 4'h8);
    assign is_wr_block  = (req_type == 4'h9);
    assign is_read      = is_rd_single || is_rd_block;
    assign is_block     = is_rd_block || is_wr_block;
    assign is_unknown   = !(is_read || is_wr_single || is_wr_block);
    assign req_idx      = POReqAdrs[DEPTH_LOG2+1:2];
    // beats-1 for block sizes 2/4/8/16, also used as the alignment mask
    assign blk_last     = {POReqCntl[2:1] == 2'b11, POReqCntl[2], |POReqCntl[2:1], 1'b1};
    assign start_idx    = is_block ? (req_idx & ~DEPTH_LOG2'(blk_last)) : req_idx;
    assign id_err       = (POReqId != PIRespId);
    assign wr_done      = POReqCntl[0] || (beat == last_beat);
    assign beat_nxt     = beat + 4'd1;
    assign unused_bits  = ^{POReqCntl[3], POReqAdrs};

`ifdef PIF_SLAVE_ADDR_ERR_EN
    assign addr_err = |POReqAdrs[31:DEPTH_LOG2+2];
`else
    assign addr_err = 1'b0;
`endif

    always_comb begin
        mem_we   = 1'b0;
        mem_widx = start_idx;
        if (!BReset && accept) begin
            if (state == S_IDLE && (is_wr_single || is_wr_block) && !addr_err) begin
                mem_we = 1'b1;
            end else if (state == S_WR_COLLECT && !err[0]) begin
                mem_we   = 1'b1;
                mem_widx = base_idx + DEPTH_LOG2'(beat);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (POReqDataBE[b]) mem[mem_widx][8*b +: 8] <= POReqData[8*b +: 8];
            end
        end
    end

    // Decide which response beat (if any) gets loaded into the output registers this edge
    always_comb begin
        rd_issue  = 1'b0;
        rd_idx    = base_idx;
        rd_last   = 1'b0;
        rd_err    = err[0];
        ack_issue = 1'b0;
        ack_type  = resp_type;
        ack_err   = err;
        case (state)
            S_IDLE: begin
                if (accept && is_read && READ_LATENCY == 1) begin
                    rd_issue = 1'b1;
                    rd_idx   = start_idx;
                    rd_last  = is_rd_single;
                    rd_err   = addr_err;
                end
                if (accept && (is_wr_single || is_unknown) && WRITE_LATENCY == 1) begin
                    ack_issue = 1'b1;
                    ack_type  = is_unknown ? {3'b000, req_type[3]} : 4'h1;
                    ack_err   = is_unknown ? 3'b010 : {2'b00, addr_err};
                end
            end
            S_WR_COLLECT: begin
                if (accept && wr_done && WRITE_LATENCY == 1) begin
                    ack_issue = 1'b1;
                    ack_err   = err | {id_err, 2'b00};
                end
            end
            S_RD_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    rd_issue = 1'b1;
                    rd_last  = (last_beat == 4'd0);
                end
            end
            S_RD_RESP: begin
                if (PORespRdy && beat != last_beat) begin
                    rd_issue = 1'b1;
                    rd_idx   = base_idx + DEPTH_LOG2'(beat_nxt);
                    rd_last  = (beat_nxt == last_beat);
                end
            end
            S_WR_WAIT: begin
                if (wait_cnt == 4'd1) ack_issue = 1'b1;
            end
            default: ;
        endcase
        rd_data = rd_err ? 32'h0 : mem[rd_idx];
    end

    always_ff @(posedge CLK) begin
        if (BReset) begin
            state          <= S_IDLE;
            PIReqRdy       <= 1'b0;
            PIRespValid    <= 1'b0;
            PIRespCntl     <= '0;
            PIRespData     <= '0;
            PIRespId       <= '0;
            PIRespPriority <= '0;
            base_idx       <= '0;
            beat           <= '0;
            last_beat      <= '0;
            wait_cnt       <= '0;
            err            <= '0;
            resp_type      <= '0;
        end else begin
            if (rd_issue) begin
                PIRespValid <= 1'b1;
                PIRespData  <= rd_data;
                PIRespCntl  <= {4'h0, rd_err ? 3'b001 : 3'b000, rd_last};
            end
            if (ack_issue) begin
                PIRespValid <= 1'b1;
                PIRespData  <= 32'h0;
                PIRespCntl  <= {ack_type, ack_err, 1'b1};
            end
            case (state)
                S_IDLE: begin
                    PIReqRdy <= 1'b1;
                    if (accept) begin
                        PIRespId       <= POReqId;
                        PIRespPriority <= POReqPriority;
                        base_idx       <= start_idx;
                        last_beat      <= is_block ? blk_last : 4'd0;
                        beat           <= is_wr_block ? 4'd1 : 4'd0;
                        err            <= {2'b00, addr_err};
                        resp_type      <= 4'h1;
                        if (is_read) begin
                            PIReqRdy <= 1'b0;
                            wait_cnt <= RD_WAIT_INIT;
                            state    <= (READ_LATENCY == 1) ? S_RD_RESP : S_RD_WAIT;
                        end else if (is_wr_block) begin
                            state <= S_WR_COLLECT;
                        end else begin
                            PIReqRdy <= 1'b0;
                            wait_cnt <= WR_WAIT_INIT;
                            state    <= (WRITE_LATENCY == 1) ? S_WR_RESP : S_WR_WAIT;
                            if (is_unknown) begin
                                err       <= 3'b010;
                                resp_type <= {3'b000, req_type[3]};
                            end
                        end
                    end
                end
                S_WR_COLLECT: begin
                    if (accept) begin
                        err  <= err | {id_err, 2'b00};
                        beat <= beat_nxt;
                        if (wr_done) begin
                            PIReqRdy <= 1'b0;
                            wait_cnt <= WR_WAIT_INIT;
                            state    <= (WRITE_LATENCY == 1) ? S_WR_RESP : S_WR_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (wait_cnt == 4'd1) state <= S_RD_RESP;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                S_RD_RESP: begin
                    if (PORespRdy) begin
                        if (beat == last_beat) begin
                            PIRespValid <= 1'b0;
                            PIReqRdy    <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            beat <= beat_nxt;
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (wait_cnt == 4'd1) state <= S_WR_RESP;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                S_WR_RESP: begin
                    if (PORespRdy) begin
                        PIRespValid <= 1'b0;
                        PIReqRdy    <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pif_slave_memory_responder.sv
`default_nettype none
// Bench for pif_slave_memory_responder: directed requests against a word-memory model
// with an expected-response queue compared every cycle.
module tb_pif_slave_memory_responder;

    localparam int DEPTH_LOG2 = 10;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef PIF_SLAVE_ADDR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        BReset;
    logic        POReqValid;
    logic        PIReqRdy;
    logic [7:0]  POReqCntl;
    logic [31:0] POReqAdrs;
    logic [31:0] POReqData;
    logic [3:0]  POReqDataBE;
    logic [5:0]  POReqId;
    logic [1:0]  POReqPriority;
    logic        PIRespValid;
    logic        PORespRdy;
    logic [7:0]  PIRespCntl;
    logic [31:0] PIRespData;
    logic [5:0]  PIRespId;
    logic [1:0]  PIRespPriority;

    pif_slave_memory_responder #(
        .DEPTH_LOG2(DEPTH_LOG2), .READ_LATENCY(1), .WRITE_LATENCY(1)
    ) dut (
        .CLK(clk), .BReset(BReset),
        .POReqValid(POReqValid), .PIReqRdy(PIReqRdy), .POReqCntl(POReqCntl),
        .POReqAdrs(POReqAdrs), .POReqData(POReqData), .POReqDataBE(POReqDataBE),
        .POReqId(POReqId), .POReqPriority(POReqPriority),
        .PIRespValid(PIRespValid), .PORespRdy(PORespRdy), .PIRespCntl(PIRespCntl),
        .PIRespData(PIRespData), .PIRespId(PIRespId), .PIRespPriority(PIRespPriority)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cntl;
        logic [7:0]  cmask;
        logic [31:0] data;
        logic [31:0] dmask;
        logic [5:0]  id;
        logic [1:0]  prio;
    } beat_t;

    typedef struct {
        logic [7:0]  cntl;
        logic [31:0] data;
        logic [5:0]  id;
    } got_t;

    beat_t       exp_q[$];
    got_t        got_q[$];
    logic [31:0] mdl [DEPTH];
    int          vectors = 0;
    int          miscompares = 0;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a / 32'd4) % DEPTH;
    endfunction

    function automatic bit aerr(input logic [31:0] a);
        return ERR_EN && (a >= 32'(4 * DEPTH));
    endfunction

    // Response checker: with unit latencies the responder is busy exactly while responses are owed
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_rdy", {31'b0, PIReqRdy}, {31'b0, exp_q.size() == 0});
            check("resp_valid", {31'b0, PIRespValid}, {31'b0, exp_q.size() != 0});
            if (PIRespValid && exp_q.size() != 0) begin
                check("resp_cntl", {24'b0, PIRespCntl & exp_q[0].cmask},
                      {24'b0, exp_q[0].cntl & exp_q[0].cmask});
                check("resp_data", PIRespData & exp_q[0].dmask, exp_q[0].data & exp_q[0].dmask);
                check("resp_id", {26'b0, PIRespId}, {26'b0, exp_q[0].id});
                check("resp_prio", {30'b0, PIRespPriority}, {30'b0, exp_q[0].prio});
                if (PORespRdy) begin
                    got_q.push_back('{cntl: PIRespCntl, data: PIRespData, id: PIRespId});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic push_beat(input logic [7:0] cntl, input logic [7:0] cmask, input logic [31:0] data,
                             input logic [31:0] dmask, input logic [5:0] id, input logic [1:0] prio);
        exp_q.push_back('{cntl: cntl, cmask: cmask, data: data, dmask: dmask, id: id, prio: prio});
    endtask

    task automatic send_beat(input logic [7:0] cntl, input logic [31:0] adrs, input logic [31:0] data,
                             input logic [3:0] be, input logic [5:0] id, input logic [1:0] prio);
        int n = 0;
        POReqValid = 1'b1; POReqCntl = cntl; POReqAdrs = adrs; POReqData = data;
        POReqDataBE = be; POReqId = id; POReqPriority = prio;
        do begin
            @(negedge clk);
            n++;
        end while (!PIReqRdy && n < 100);
        check("req_accept", {31'b0, PIReqRdy}, 32'd1);
        @(posedge clk);
        #1;
        POReqValid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("resp_drain", exp_q.size(), 32'd0);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [5:0] id, input logic [1:0] prio);
        send_beat(8'h81, a, d, be, id, prio);
        if (!aerr(a)) begin
            for (int b = 0; b < 4; b++) if (be[b]) mdl[widx(a)][8*b +: 8] = d[8*b +: 8];
        end
        push_beat({4'h1, aerr(a) ? 3'b001 : 3'b000, 1'b1}, 8'hFF, 32'h0, 32'h0, id, prio);
        wait_idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [5:0] id, input logic [1:0] prio);
        send_beat(8'h01, a, 32'h0, 4'h0, id, prio);
        push_beat({4'h0, aerr(a) ? 3'b001 : 3'b000, 1'b1}, 8'hFF,
                  aerr(a) ? 32'h0 : mdl[widx(a)], 32'hFFFF_FFFF, id, prio);
        wait_idle();
    endtask

    task automatic blk_rd(input logic [31:0] a, input logic [1:0] bsize, input logic [5:0] id,
                          input logic [1:0] prio);
        int n = 2 << bsize;
        int base = widx(a) - (widx(a) % n);
        send_beat({4'h1, 1'b0, bsize, 1'b1}, a, 32'h0, 4'h0, id, prio);
        for (int i = 0; i < n; i++) begin
            push_beat({4'h0, aerr(a) ? 3'b001 : 3'b000, 1'(i == n - 1)}, 8'hFF,
                      aerr(a) ? 32'h0 : mdl[(base + i) % DEPTH], 32'hFFFF_FFFF, id, prio);
        end
    endtask

    // bad: beat index sent with a wrong id (-1 none); stop: index of final beat sent
    task automatic blk_wr(input logic [31:0] a, input logic [1:0] bsize, input logic [31:0] d0,
                          input logic [5:0] id, input logic [1:0] prio, input int bad,
                          input int stop, input bit mark_last);
        int n = 2 << bsize;
        int base = widx(a) - (widx(a) % n);
        logic [2:0] e = aerr(a) ? 3'b001 : 3'b000;
        logic [5:0] bid;
        for (int i = 0; i <= stop; i++) begin
            bid = (i == bad) ? (id ^ 6'h01) : id;
            send_beat({4'h9, 1'b0, bsize, 1'(mark_last && i == stop)}, a + 32'(4 * i),
                      d0 + 32'(i), 4'hF, bid, prio);
            if (!aerr(a)) mdl[(base + i) % DEPTH] = d0 + 32'(i);
            if (bid != id) e = e | 3'b100;
        end
        push_beat({4'h1, e, 1'b1}, 8'hFF, 32'h0, 32'h0, id, prio);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        BReset = 1'b1; POReqValid = 1'b0; POReqCntl = '0; POReqAdrs = '0; POReqData = '0;
        POReqDataBE = '0; POReqId = '0; POReqPriority = '0; PORespRdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_rdy", {31'b0, PIReqRdy}, 32'd0);
        check("rst_valid", {31'b0, PIRespValid}, 32'd0);
        check("rst_cntl", {24'b0, PIRespCntl}, 32'd0);
        check("rst_data", PIRespData, 32'd0);
        check("rst_id", {26'b0, PIRespId}, 32'd0);
        check("rst_prio", {30'b0, PIRespPriority}, 32'd0);
        BReset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_rdy", {31'b0, PIReqRdy}, 32'd1);
        chk_en = 1'b1;

        // single write then read back
        wr(32'h10, 32'hDEADBEEF, 4'hF, 6'd5, 2'd0);
        check("t1_ack_cntl", {24'b0, got_q[$].cntl}, 32'h11);
        check("t1_ack_id", {26'b0, got_q[$].id}, 32'd5);
        rd(32'h10, 6'd5, 2'd2);
        check("t1_rd_data", got_q[$].data, 32'hDEADBEEF);

        // byte-enable merge, and BE=0 leaves the word alone
        wr(32'h20, 32'h11223344, 4'hF, 6'd1, 2'd1);
        wr(32'h20, 32'hAABBCCDD, 4'b0101, 6'd1, 2'd1);
        check("t2_model", mdl[8], 32'h11BB33DD);
        rd(32'h20, 6'd2, 2'd0);
        check("t2_rd_data", got_q[$].data, 32'h11BB33DD);
        wr(32'h20, 32'hFFFF_FFFF, 4'h0, 6'd3, 2'd0);
        rd(32'h20, 6'd3, 2'd0);
        check("t2_be0_data", got_q[$].data, 32'h11BB33DD);

        // block write 4 ending by count, block read from a misaligned address
        blk_wr(32'h40, 2'b01, 32'd1, 6'd3, 2'd0, -1, 3, 1'b0);
        blk_rd(32'h48, 2'b01, 6'd4, 2'd3);
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            check("t3_beat_data", got_q[got_q.size() - 4 + k].data, 32'(k + 1));
            check("t3_beat_last", {31'b0, got_q[got_q.size() - 4 + k].cntl[0]}, 32'(k == 3));
        end

        // 8-beat block read with 3 stalled cycles on beat 2
        blk_wr(32'h200, 2'b10, 32'h100, 6'd8, 2'd1, -1, 7, 1'b1);
        blk_rd(32'h20C, 2'b10, 6'd9, 2'd2);
        repeat (2) @(posedge clk);
        #1;
        PORespRdy = 1'b0;
        check("t4_stall_data0", PIRespData, 32'h102);
        repeat (3) @(posedge clk);
        #1;
        check("t4_stall_data3", PIRespData, 32'h102);
        check("t4_stall_rdy", {31'b0, PIReqRdy}, 32'd0);
        PORespRdy = 1'b1;
        wait_idle();

        // 16-beat block
        blk_wr(32'h33C, 2'b11, 32'h1000, 6'd12, 2'd3, -1, 15, 1'b1);
        blk_rd(32'h304, 2'b11, 6'd13, 2'd0);
        wait_idle();
        check("t16_last_data", got_q[$].data, 32'h100F);

        // id mismatch on beat 1 still writes, ack flags 3'b100
        blk_wr(32'h80, 2'b00, 32'hA0, 6'd9, 2'd0, 1, 1, 1'b1);
        check("id_err_ack", {24'b0, got_q[$].cntl}, 32'h19);
        rd(32'h84, 6'd9, 2'd0);
        check("id_err_data", got_q[$].data, 32'hA1);

        // early last beat ends a 4-beat block write after 2 beats
        blk_wr(32'hC0, 2'b01, 32'hB0, 6'd2, 2'd0, -1, 1, 1'b1);
        rd(32'hC4, 6'd2, 2'd0);
        check("early_last_data", got_q[$].data, 32'hB1);

        // unknown request type
        send_beat(8'h21, 32'h0, 32'h0, 4'h0, 6'd4, 2'd1);
        push_beat(8'h05, 8'h0F, 32'h0, 32'h0, 6'd4, 2'd1);
        wait_idle();
        check("unknown_err", {24'b0, got_q[$].cntl & 8'h0F}, 32'h05);

        // out-of-range address
        wr(32'h0, 32'hCAFEF00D, 4'hF, 6'd1, 2'd0);
        rd(32'h0001_0000, 6'd1, 2'd0);
        if (ERR_EN) check("oor_data", got_q[$].data, 32'h0);
        else        check("alias_data", got_q[$].data, 32'hCAFEF00D);

        // reset during beat 1 of a 4-beat block read
        PORespRdy = 1'b0;
        blk_rd(32'h40, 2'b01, 6'd7, 2'd1);
        @(posedge clk);
        #1;
        PORespRdy = 1'b1;
        @(posedge clk);
        #1;
        PORespRdy = 1'b0;
        check("rr_beat1_data", PIRespData, 32'd2);
        chk_en = 1'b0;
        BReset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("rr_valid", {31'b0, PIRespValid}, 32'd0);
        check("rr_req_rdy", {31'b0, PIReqRdy}, 32'd0);
        check("rr_cntl", {24'b0, PIRespCntl}, 32'd0);
        check("rr_id", {26'b0, PIRespId}, 32'd0);
        BReset = 1'b0;
        PORespRdy = 1'b1;
        @(posedge clk);
        #1;
        check("rr_rdy_after", {31'b0, PIReqRdy}, 32'd1);
        chk_en = 1'b1;
        rd(32'h40, 6'd6, 2'd0);
        check("rr_new_read", got_q[$].data, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
